// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: grant record and one-hot decode helper.
// Widths are sized for the largest supported requester count; users cast down to N.
package ram_arb_pkg;

  localparam int ARB_MAX_N = 32;
  localparam int ARB_ID_W  = 5;

  typedef struct packed {
    logic [ARB_MAX_N-1:0] onehot;
    logic [ARB_ID_W-1:0]  id;
  } rr_grant_t;

  function automatic logic [ARB_ID_W-1:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh);
    logic [ARB_ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) bin = bin | ARB_ID_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves to winner+1 after every grant.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr;
  rr_grant_t     sel;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int idx;
    sel = '0;
    idx = 0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (|(req & (N'(1) << idx))) begin
          sel.onehot = ARB_MAX_N'(1) << idx;
        end
      end
    end
    sel.id = onehot2bin(sel.onehot);
  end

  assign gnt    = N'(sel.onehot);
  assign gnt_id = IW'(sel.id);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (|sel.onehot) begin
      ptr <= (sel.id >= ARB_ID_W'(N - 1)) ? '0 : IW'(sel.id + 1'b1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1R1W synchronous RAM among NUM_REQ requesters with independent
// round-robin read and write arbitration and write-first collision bypass.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int RAM_DATA_WIDTH = 32,
  parameter  int RAM_DEPTH      = 512,
  localparam int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    i_rst,
  input  logic [NUM_REQ-1:0]                      rd_req_valid,
  input  logic [NUM_REQ-1:0][RAM_ADDR_WIDTH-1:0]  rd_req_addr,
  output logic [NUM_REQ-1:0]                      rd_req_ready,
  input  logic [NUM_REQ-1:0]                      wr_req_valid,
  input  logic [NUM_REQ-1:0][RAM_ADDR_WIDTH-1:0]  wr_req_addr,
  input  logic [NUM_REQ-1:0][RAM_DATA_WIDTH-1:0]  wr_req_data,
  output logic [NUM_REQ-1:0]                      wr_req_ready,
  output logic                                    rd_rsp_valid,
  output logic [ID_WIDTH-1:0]                     rd_rsp_id,
  output logic [RAM_DATA_WIDTH-1:0]               rd_rsp_data,
  output logic                                    ram_re,
  output logic [RAM_ADDR_WIDTH-1:0]               ram_raddr,
  output logic                                    ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]               ram_waddr,
  output logic [RAM_DATA_WIDTH-1:0]               ram_wdata,
  input  logic [RAM_DATA_WIDTH-1:0]               ram_rdata
);

  logic [ID_WIDTH-1:0]       rd_id;
  logic [ID_WIDTH-1:0]       wr_id;
  logic                      byp_flag;
  logic [RAM_DATA_WIDTH-1:0] byp_data;
  logic                      collide;

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk    (clk),
    .i_rst  (i_rst),
    .req    (rd_req_valid),
    .en     (~i_rst),
    .gnt    (rd_req_ready),
    .gnt_id (rd_id)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk    (clk),
    .i_rst  (i_rst),
    .req    (wr_req_valid),
    .en     (~i_rst),
    .gnt    (wr_req_ready),
    .gnt_id (wr_id)
  );

  assign ram_re    = |rd_req_ready;
  assign ram_raddr = rd_req_addr[rd_id];
  assign ram_we    = |wr_req_ready;
  assign ram_waddr = wr_req_addr[wr_id];
  assign ram_wdata = wr_req_data[wr_id];

  // The RAM returns old data on a same-address read/write; capture the write to forward it.
  assign collide = ram_re & ram_we & (ram_raddr == ram_waddr);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_id    <= '0;
      byp_flag     <= 1'b0;
      byp_data     <= '0;
    end else begin
      rd_rsp_valid <= ram_re;
      if (ram_re) rd_rsp_id <= rd_id;
      byp_flag <= collide;
      if (ram_we) byp_data <= ram_wdata;
    end
  end

  assign rd_rsp_data = byp_flag ? byp_data : ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized bench for ram_port_arbiter against a queue/array-level
// reference model, with a behavioural 1R1W RAM attached to the RAM ports.
module tb_ram_port_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  i_rst;
  logic [N-1:0]          rd_req_valid;
  logic [N-1:0][AW-1:0]  rd_req_addr;
  logic [N-1:0]          rd_req_ready;
  logic [N-1:0]          wr_req_valid;
  logic [N-1:0][AW-1:0]  wr_req_addr;
  logic [N-1:0][DW-1:0]  wr_req_data;
  logic [N-1:0]          wr_req_ready;
  logic                  rd_rsp_valid;
  logic [IDW-1:0]        rd_rsp_id;
  logic [DW-1:0]         rd_rsp_data;
  logic                  ram_re;
  logic [AW-1:0]         ram_raddr;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [DW-1:0]         ram_wdata;
  logic [DW-1:0]         ram_rdata = '0;

  ram_port_arbiter #(.NUM_REQ(N), .RAM_DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_ready (rd_req_ready),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_ready (wr_req_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_id    (rd_rsp_id),
    .rd_rsp_data  (rd_rsp_data),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Behavioural RAM: registered read returning old data on a same-address write.
  logic          ram_clr;
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_re) ram_rdata <= ram_mem[ram_raddr];
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    end
  end

  // Reference model state
  logic [DW-1:0] exp_mem [DEPTH];
  int            rptr, wptr, g_r, g_w;
  bit            exp_v;
  int            exp_id;
  logic [DW-1:0] exp_d;
  int            total = 0;
  int            bad   = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = (i - p + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [N-1:0] er, ew;
    @(negedge clk);
    g_r = i_rst ? -1 : pick(rd_req_valid, rptr);
    g_w = i_rst ? -1 : pick(wr_req_valid, wptr);
    er  = (g_r >= 0) ? (N'(1) << g_r) : '0;
    ew  = (g_w >= 0) ? (N'(1) << g_w) : '0;
    check("rd_ready", 64'(rd_req_ready), 64'(er));
    check("wr_ready", 64'(wr_req_ready), 64'(ew));
    check("ram_re", 64'(ram_re), 64'(g_r >= 0));
    check("ram_we", 64'(ram_we), 64'(g_w >= 0));
    if (g_r >= 0) check("ram_raddr", 64'(ram_raddr), 64'(rd_req_addr[g_r]));
    if (g_w >= 0) begin
      check("ram_waddr", 64'(ram_waddr), 64'(wr_req_addr[g_w]));
      check("ram_wdata", 64'(ram_wdata), 64'(wr_req_data[g_w]));
    end
    check("rsp_valid", 64'(rd_rsp_valid), 64'(exp_v));
    if (exp_v) begin
      check("rsp_id", 64'(rd_rsp_id), 64'(exp_id));
      check("rsp_data", 64'(rd_rsp_data), 64'(exp_d));
    end
  endtask

  task automatic advance();
    logic [AW-1:0] ra;
    @(posedge clk);
    if (i_rst) begin
      rptr  = 0;
      wptr  = 0;
      exp_v = 1'b0;
    end else begin
      exp_v = (g_r >= 0);
      if (g_r >= 0) begin
        ra     = rd_req_addr[g_r];
        exp_id = g_r;
        exp_d  = (g_w >= 0 && wr_req_addr[g_w] == ra) ? wr_req_data[g_w] : exp_mem[ra];
        rptr   = (g_r + 1) % N;
      end
      if (g_w >= 0) begin
        exp_mem[wr_req_addr[g_w]] = wr_req_data[g_w];
        wptr = (g_w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    rptr = 0; wptr = 0; exp_v = 1'b0; exp_id = 0; exp_d = '0;
    i_rst = 1'b1; ram_clr = 1'b1;
    rd_req_valid = '1; wr_req_valid = '1;
    rd_req_addr = '0; wr_req_addr = '0; wr_req_data = '0;

    // Reset with every requester asking
    cyc();
    ram_clr = 1'b0;
    cyc();
    check("rst_rsp_id", 64'(rd_rsp_id), 64'(0));
    i_rst = 1'b0;
    rd_req_valid = '0; wr_req_valid = '0;

    // Round-robin over all four readers
    for (int i = 0; i < N; i++) rd_req_addr[i] = AW'(16 + i);
    rd_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr_seq", 64'(rd_req_ready), 64'(1 << (k % 4)));
      if (k > 0) check("rr_rsp_id", 64'(rd_rsp_id), 64'((k - 1) % 4));
      advance();
    end
    rd_req_valid = '0;
    cyc();

    // Wrap and skip: move pointer to 3, then alternate between 0 and 2
    rd_req_valid = 4'b0100;
    cyc();
    rd_req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("wrap_skip", 64'(rd_req_ready), (k == 1) ? 64'(4'b0100) : 64'(4'b0001));
      advance();
    end
    rd_req_valid = '0;

    // Same-cycle read/write collision on address 5
    wr_req_valid = 4'b0010; wr_req_addr[1] = 9'd5; wr_req_data[1] = 32'hDEADBEEF;
    rd_req_valid = 4'b0100; rd_req_addr[2] = 9'd5;
    cyc();
    rd_req_valid = '0; wr_req_valid = '0;
    settle();
    check("coll_valid", 64'(rd_rsp_valid), 64'(1));
    check("coll_id", 64'(rd_rsp_id), 64'(2));
    check("coll_data", 64'(rd_rsp_data), 64'(32'hDEADBEEF));
    advance();

    // Read latency from addr 7
    wr_req_valid = 4'b0001; wr_req_addr[0] = 9'd7; wr_req_data[0] = 32'h12345678;
    cyc();
    wr_req_valid = '0;
    rd_req_valid = 4'b1000; rd_req_addr[3] = 9'd7;
    cyc();
    rd_req_valid = '0;
    settle();
    check("lat_valid", 64'(rd_rsp_valid), 64'(1));
    check("lat_data", 64'(rd_rsp_data), 64'(32'h12345678));
    advance();
    settle();
    check("lat_gone", 64'(rd_rsp_valid), 64'(0));
    advance();

    // Reset in the middle of a read
    rd_req_valid = 4'b0010; rd_req_addr[1] = 9'd7;
    cyc();
    i_rst = 1'b1; rd_req_valid = 4'b1111;
    settle();
    check("rstmid_v1", 64'(rd_rsp_valid), 64'(1));
    advance();
    settle();
    check("rstmid_v0", 64'(rd_rsp_valid), 64'(0));
    advance();
    i_rst = 1'b0;
    settle();
    check("rstmid_ptr", 64'(rd_req_ready), 64'(4'b0001));
    advance();
    rd_req_valid = '0;

    // Randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      i_rst        = ($urandom_range(0, 59) == 0);
      rd_req_valid = N'($urandom_range(0, 15));
      wr_req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        rd_req_addr[i] = AW'($urandom_range(0, 7));
        wr_req_addr[i] = AW'($urandom_range(0, 7));
        wr_req_data[i] = $urandom;
      end
      cyc();
    end
    i_rst = 1'b0; rd_req_valid = '0; wr_req_valid = '0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
